// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demultiplexer: in_sel steers each input word into
// lane A or lane B, each backed by its own DEPTH-entry FIFO.
module demux_stream #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  a_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [CW-1:0] a_count,
  output logic [W-1:0]  b_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [CW-1:0] b_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] Full    = CW'(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  // Index 0 is lane A, index 1 is lane B.
  logic [W-1:0]  mem_q    [2][DEPTH];
  logic [W-1:0]  mem_d    [2][DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] count_q  [2];
  logic [CW-1:0] count_d  [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full[0]  = (count_q[0] == Full);
  assign full[1]  = (count_q[1] == Full);
  assign valid[0] = (count_q[0] != '0);
  assign valid[1] = (count_q[1] != '0);

  // Only the selected lane's full flag matters; a pop this cycle does not free space.
  assign in_ready = !rst && !full[in_sel];
  assign push[0]  = in_valid && in_ready && !in_sel;
  assign push[1]  = in_valid && in_ready && in_sel;
  assign pop[0]   = valid[0] && a_ready;
  assign pop[1]   = valid[1] && b_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int l = 0; l < 2; l++) begin
      if (push[l]) begin
        mem_d[l][wr_ptr_q[l]] = in_data;
        wr_ptr_d[l]           = ptr_inc(wr_ptr_q[l]);
      end
      if (pop[l]) begin
        rd_ptr_d[l] = ptr_inc(rd_ptr_q[l]);
      end
      case ({push[l], pop[l]})
        2'b10:   count_d[l] = count_q[l] + 1'b1;
        2'b01:   count_d[l] = count_q[l] - 1'b1;
        default: count_d[l] = count_q[l];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      count_q  <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; push is already gated off while rst is high.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign a_data  = mem_q[0][rd_ptr_q[0]];
  assign b_data  = mem_q[1][rd_ptr_q[1]];
  assign a_valid = valid[0];
  assign b_valid = valid[1];
  assign a_count = count_q[0];
  assign b_count = count_q[1];

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a W=2/DEPTH=2 instance for routing, backpressure
// and reset, plus a W=8/DEPTH=3 instance for wrap-around ordering.
module tb_demux_stream;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic [1:0] in_data;
  logic       in_sel, in_valid, in_ready;
  logic [1:0] a_data, b_data;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [1:0] a_count, b_count;

  logic [7:0] w_in_data;
  logic       w_in_sel, w_in_valid, w_in_ready;
  logic [7:0] w_a_data, w_b_data;
  logic       w_a_valid, w_b_valid, w_a_ready, w_b_ready;
  logic [1:0] w_a_count, w_b_count;

  int n_cmp  = 0;
  int n_fail = 0;

  demux_stream #(.W(2), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_count(a_count),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .b_count(b_count)
  );

  demux_stream #(.W(8), .DEPTH(3)) dut_w (
    .clk(clk), .rst(rst),
    .in_data(w_in_data), .in_sel(w_in_sel), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a_data(w_a_data), .a_valid(w_a_valid), .a_ready(w_a_ready), .a_count(w_a_count),
    .b_data(w_b_data), .b_valid(w_b_valid), .b_ready(w_b_ready), .b_count(w_b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    logic [7:0] sent, rcvd;
    logic [1:0] mcount;
    logic       acc, pp;
    int         cyc;

    rst = 1'b1;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    w_in_valid = 1'b0; w_in_sel = 1'b0; w_in_data = '0; w_a_ready = 1'b0; w_b_ready = 1'b0;
    tick();
    drive(1'b1, 1'b0, 2'b11);
    chk("rst_in_ready", in_ready, 0);
    tick();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);

    // Routing
    drive(1'b0, 1'b0, 2'b00);
    rst = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b01);
    chk("route_in_ready0", in_ready, 1);
    chk("route_a_empty0", a_valid, 0);
    tick();
    drive(1'b1, 1'b1, 2'b10);
    chk("route_a_valid", a_valid, 1);
    chk("route_a_data", a_data, 2'b01);
    chk("route_a_count", a_count, 1);
    chk("route_b_empty", b_valid, 0);
    chk("route_in_ready1", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, 2'b00);
    chk("route_b_valid", b_valid, 1);
    chk("route_b_data", b_data, 2'b10);
    chk("route_a_drained", a_count, 0);
    tick();
    chk("route_b_drained", b_count, 0);
    chk("route_b_valid_off", b_valid, 0);

    // Backpressure and push at full with pop
    a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 2'b01);
    chk("bp_ready_second", in_ready, 1);
    tick();
    drive(1'b1, 1'b0, 2'b10);
    chk("bp_a_full", a_count, 2);
    chk("bp_in_ready_full", in_ready, 0);
    tick();
    chk("bp_count_held", a_count, 2);
    drive(1'b1, 1'b1, 2'b11);
    chk("bp_other_lane_ready", in_ready, 1);
    tick();
    chk("bp_b_count", b_count, 1);
    chk("bp_b_data", b_data, 2'b11);
    a_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b10);
    chk("full_pop_in_ready", in_ready, 0);
    chk("bp_head0", a_data, 2'b00);
    tick();
    chk("full_pop_count", a_count, 1);
    chk("bp_head1", a_data, 2'b01);
    chk("bp_ready_after_pop", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, 2'b00);
    chk("pushpop_count", a_count, 1);
    chk("bp_head2", a_data, 2'b10);
    tick();
    chk("bp_a_empty", a_count, 0);
    b_ready = 1'b1;
    tick();
    chk("bp_b_empty", b_count, 0);

    // Reset mid-operation
    a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b01); tick();
    drive(1'b1, 1'b0, 2'b10); tick();
    drive(1'b1, 1'b1, 2'b10); tick();
    drive(1'b1, 1'b1, 2'b01); tick();
    chk("mid_a_count", a_count, 2);
    chk("mid_b_count", b_count, 2);
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00);
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    chk("mid_a_valid", a_valid, 0);
    chk("mid_b_valid", b_valid, 0);
    chk("mid_a_count0", a_count, 0);
    chk("mid_b_count0", b_count, 0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'b11);
    tick();
    drive(1'b0, 1'b0, 2'b00);
    chk("post_b_valid", b_valid, 1);
    chk("post_b_data", b_data, 2'b11);
    chk("post_b_count", b_count, 1);
    chk("post_a_valid", a_valid, 0);
    b_ready = 1'b1;
    tick();
    chk("post_b_drained", b_count, 0);

    // Idle: pops on empty lanes and sel toggling without valid
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, i[0], 2'($urandom));
      tick();
      chk("idle_a_valid", a_valid, 0);
      chk("idle_b_valid", b_valid, 0);
      chk("idle_a_count", a_count, 0);
      chk("idle_b_count", b_count, 0);
    end

    // Wrap-around ordering on DEPTH=3
    sent = 0; rcvd = 0; mcount = 0;
    for (cyc = 0; cyc < 300 && rcvd < 20; cyc++) begin
      w_in_valid = (sent < 20);
      w_in_sel   = 1'b0;
      w_in_data  = 8'h40 + sent;
      w_a_ready  = (cyc >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
      w_b_ready  = 1'b1;
      #1;
      chk("wrap_count", w_a_count, mcount);
      chk("wrap_in_ready", w_in_ready, (mcount != 2'd3));
      chk("wrap_b_idle", w_b_valid, 0);
      acc = w_in_valid && (mcount != 2'd3);
      pp  = w_a_ready && (mcount != 2'd0);
      if (pp) begin
        chk("wrap_order", w_a_data, 8'h40 + rcvd);
        rcvd++;
      end
      if (acc) sent++;
      mcount = mcount + 2'(acc) - 2'(pp);
      tick();
    end
    chk("wrap_all_received", rcvd, 20);
    chk("wrap_final_count", w_a_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
